// File: rtl/mem_master_pkg.sv
// mem_master_pkg: shared sizes and FSM state type for the data-memory initiator.
// Used by mem_master, its bus interface and the CPU top.
package mem_master_pkg;

    localparam int MEM_AW = 5;
    localparam int MEM_DW = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RCAP,
        WR,
        VRD,
        VCAP
    } mm_state_t;

endpackage

// File: rtl/mem_master_if.sv
// mem_master_if: CPU request/response handshake plus data-memory strobes.
// master = mem_master side, slave = CPU/memory side.
interface mem_master_if
    import mem_master_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
);

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wdata, mem_rd, mem_wr
    );

endinterface

// File: rtl/mem_master.sv
// mem_master: single-request initiator for the 32x8 registered-read data memory.
// Define MEM_MASTER_WRITE_VERIFY_EN to add write readback verification.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input logic          clk,
    input logic          rst,
    mem_master_if.master bus
);

    mm_state_t     state;
    mm_state_t     state_nx;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          rd_q;
    logic          wr_q;
    logic          vld_q;
    logic          rsp_nx;
    logic          cap_nx;
    logic          accept;

    assign accept = (state == IDLE) && bus.req_valid;

`ifdef MEM_MASTER_WRITE_VERIFY_EN
    logic err_q;
    logic err_nx;
`endif

    always_comb begin
        state_nx = state;
        rsp_nx   = 1'b0;
        cap_nx   = 1'b0;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
        err_nx   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (bus.req_valid)
                    state_nx = bus.req_we ? WR : RD;
            end
            RD: state_nx = RCAP;
            RCAP: begin
                state_nx = IDLE;
                rsp_nx   = 1'b1;
                cap_nx   = 1'b1;
            end
`ifdef MEM_MASTER_WRITE_VERIFY_EN
            WR: state_nx = VRD;
            VRD: state_nx = VCAP;
            VCAP: begin
                state_nx = IDLE;
                rsp_nx   = 1'b1;
                cap_nx   = 1'b1;
                err_nx   = (bus.mem_rdata != wdata_q);
            end
`else
            WR: begin
                state_nx = IDLE;
                rsp_nx   = 1'b1;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Strobes are registered from the next state so they align with RD/WR/VRD.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (cap_nx)
                rdata_q <= bus.mem_rdata;
            rd_q  <= (state_nx == RD) || (state_nx == VRD);
            wr_q  <= (state_nx == WR);
            vld_q <= rsp_nx;
        end
    end

`ifdef MEM_MASTER_WRITE_VERIFY_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= err_nx;
    end

    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_rd    = rd_q;
    assign bus.mem_wr    = wr_q;

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed stimulus with a transaction-level reference model.
// Includes a 32x8 registered-read memory that can corrupt one address.
module tb_mem_master;

`ifdef MEM_MASTER_WRITE_VERIFY_EN
    localparam int WLAT = 4;
    localparam bit VER  = 1'b1;
`else
    localparam int WLAT = 2;
    localparam bit VER  = 1'b0;
`endif

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   corrupt;

    mem_master_if bus ();

    mem_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Memory: write at the strobe edge, registered read data one cycle later.
    logic [7:0] mem [32];
    always @(posedge clk) begin
        if (bus.mem_wr)
            mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd)
            bus.mem_rdata <= (int'(bus.mem_addr) == corrupt) ? 8'h00 : mem[bus.mem_addr];
    end

    // Reference model: one outstanding transaction with due cycles.
    logic [7:0] gold [32];
    bit         started;
    bit         rstd;
    bit         p_valid;
    bit         p_we;
    bit         p_rdresp;
    bit         p_err;
    int         p_acc;
    int         p_due;
    int         p_rdc;
    logic [7:0] p_rdata;
    logic [7:0] exp_rdata;
    logic [4:0] exp_addr;
    logic [7:0] exp_wdata;

    always @(negedge clk) begin
        bit e_ready, e_rsp, e_rd, e_wr;
        if (started) begin
            e_ready = !(p_valid && cyc < p_due);
            e_rsp   = p_valid && (cyc == p_due);
            e_rd    = p_valid && (cyc == p_rdc);
            e_wr    = p_valid && p_we && (cyc == p_acc + 1);
            chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp));
            chk("mem_rd", 32'(bus.mem_rd), 32'(e_rd));
            chk("mem_wr", 32'(bus.mem_wr), 32'(e_wr));
            chk("rd_wr_excl", 32'(bus.mem_rd && bus.mem_wr), 32'd0);
            if (e_rsp) begin
                if (p_rdresp)
                    exp_rdata = p_rdata;
                chk("rsp_err", 32'(bus.rsp_err), 32'(p_err));
                p_valid = 1'b0;
            end
            if (rstd)
                chk("rst_err", 32'(bus.rsp_err), 32'd0);
            chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
            chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(exp_wdata));
        end
        rstd = rst;
        if (rst) begin
            started   = 1'b1;
            p_valid   = 1'b0;
            exp_rdata = 8'h00;
            exp_addr  = 5'd0;
            exp_wdata = 8'h00;
        end else if (started && bus.req_valid && !(p_valid && cyc < p_due)) begin
            p_valid   = 1'b1;
            p_acc     = cyc;
            p_we      = bus.req_we;
            exp_addr  = bus.req_addr;
            exp_wdata = bus.req_wdata;
            if (!bus.req_we) begin
                p_due    = cyc + 3;
                p_rdc    = cyc + 1;
                p_rdresp = 1'b1;
                p_rdata  = (int'(bus.req_addr) == corrupt) ? 8'h00 : gold[bus.req_addr];
                p_err    = 1'b0;
            end else begin
                gold[bus.req_addr] = bus.req_wdata;
                p_due    = cyc + WLAT;
                p_rdc    = VER ? cyc + 2 : -1;
                p_rdresp = VER;
                p_rdata  = (int'(bus.req_addr) == corrupt) ? 8'h00 : bus.req_wdata;
                p_err    = VER && (p_rdata != bus.req_wdata);
            end
        end
    end

    task automatic do_req(input logic we, input logic [4:0] a, input logic [7:0] d,
                          output int lat, output logic [7:0] rd, output logic err,
                          output logic wr1, output logic [4:0] a1);
        int t0;
        int n;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.req_ready && !rst) && n < 20);
        if (n >= 20)
            chk("accept_timeout", 32'd0, 32'd1);
        t0 = cyc;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        wr1 = bus.mem_wr;
        a1  = bus.mem_addr;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid)
            chk("rsp_timeout", 32'd0, 32'd1);
        lat = cyc - t0;
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
    endtask

    initial begin
        int         lat;
        int         n;
        int         acc;
        int         last;
        int         gap [4];
        logic [7:0] rd;
        logic       err;
        logic       wr1;
        logic [4:0] a1;

        corrupt       = -1;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 5'd0;
        bus.req_wdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: write A5 to 3, read it back
        do_req(1'b1, 5'd3, 8'hA5, lat, rd, err, wr1, a1);
        chk("t1_wr_strobe", 32'(wr1), 32'd1);
        chk("t1_wr_addr", 32'(a1), 32'd3);
        chk("t1_wr_lat", 32'(lat), 32'(WLAT));
        do_req(1'b0, 5'd3, 8'h00, lat, rd, err, wr1, a1);
        chk("t1_rd_lat", 32'(lat), 32'd3);
        chk("t1_rdata", 32'(rd), 32'hA5);

        // 2: addr = data over the full range, read back in reverse
        for (int a = 0; a < 32; a++)
            do_req(1'b1, 5'(a), 8'(a), lat, rd, err, wr1, a1);
        for (int a = 31; a >= 0; a--) begin
            do_req(1'b0, 5'(a), 8'h00, lat, rd, err, wr1, a1);
            chk("t2_rdata", 32'(rd), 32'(a));
        end

        // 3: req_valid held high, alternating read/write
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 5'd20;
        bus.req_wdata = 8'h94;
        n    = 0;
        acc  = 0;
        last = 0;
        while (acc < 5 && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.req_ready && !rst) begin
                if (acc > 0)
                    gap[acc-1] = cyc - last;
                last = cyc;
                acc++;
                @(posedge clk); #1;
                if (acc == 5) begin
                    bus.req_valid = 1'b0;
                end else begin
                    bus.req_we    = ~bus.req_we;
                    bus.req_addr  = bus.req_addr + 5'd1;
                    bus.req_wdata = bus.req_wdata + 8'd1;
                end
            end
        end
        chk("t3_accepts", 32'(acc), 32'd5);
        for (int i = 0; i < 4; i++)
            chk("t3_gap", 32'(gap[i]), (i % 2 == 0) ? 32'd3 : 32'(WLAT));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < 20);
        chk("t3_drain", 32'(bus.rsp_valid), 32'd1);

        // 4: corrupted readback at addr 7, clean write at addr 8
        corrupt = 7;
        do_req(1'b1, 5'd7, 8'h3C, lat, rd, err, wr1, a1);
        chk("t4_bad_lat", 32'(lat), 32'(WLAT));
        chk("t4_bad_err", 32'(err), 32'(VER));
        if (VER)
            chk("t4_bad_rdata", 32'(rd), 32'h00);
        do_req(1'b1, 5'd8, 8'hC3, lat, rd, err, wr1, a1);
        chk("t4_ok_err", 32'(err), 32'd0);
        if (VER)
            chk("t4_ok_rdata", 32'(rd), 32'hC3);
        corrupt = -1;

        // 5: reset in cycle 2 of a read
        do_req(1'b0, 5'd9, 8'h00, lat, rd, err, wr1, a1);
        chk("t5_pre_rdata", 32'(rd), 32'd9);
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 5'd10;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 20);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("t5_rd_c1", 32'(bus.mem_rd), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_ready", 32'(bus.req_ready), 32'd1);
        chk("t5_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t5_rdata", 32'(bus.rsp_rdata), 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end

        // 6: req_valid held through reset
        @(posedge clk); #1;
        rst           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 5'd5;
        @(negedge clk);
        repeat (2) begin
            @(negedge clk);
            chk("t6_ready", 32'(bus.req_ready), 32'd1);
            chk("t6_rd", 32'(bus.mem_rd), 32'd0);
            chk("t6_wr", 32'(bus.mem_wr), 32'd0);
            chk("t6_vld", 32'(bus.rsp_valid), 32'd0);
            chk("t6_addr", 32'(bus.mem_addr), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_first_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("t6_rd_c1", 32'(bus.mem_rd), 32'd1);
        chk("t6_addr_c1", 32'(bus.mem_addr), 32'd5);
        @(negedge clk);
        @(negedge clk);
        chk("t6_rsp", 32'(bus.rsp_valid), 32'd1);
        chk("t6_rdata", 32'(bus.rsp_rdata), 32'd5);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_master.md
# mem_master

Initiator for the CPU's 32x8 synchronous data memory. Accepts single read/write requests from the CPU datapath over a valid/ready handshake and generates the memory strobes (`mem_rd`, `mem_wr`, `mem_addr`, `mem_wdata`). It guarantees that `rd` and `wr` are never high together and absorbs the memory's one-cycle registered read latency. It returns one response pulse per request, with optional write readback verification.

## Interface
Parameters:
- `AW`, 5: address width.
- `DW`, 8: data width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; a transfer occurs on an edge where `req_valid && req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in AW: target address.
- `req_wdata` in DW: write data.
- `rsp_valid` out 1: one-cycle completion pulse. There is no backpressure.
- `rsp_rdata` out DW: read data. Holds its value until the next read response.
- `rsp_err` out 1: verify mismatch. Valid only with `rsp_valid`.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rd` out 1: memory read strobe.
- `mem_wr` out 1: memory write strobe.
- `mem_rdata` in DW: memory registered read data.

## Operation
- FSM states: IDLE, RD, RCAP, WR, VRD, VCAP.
- All outputs are registered.
- IDLE:
  - `req_ready`=1.
  - On accept, latch `req_addr` into `mem_addr` and `req_wdata` into `mem_wdata`.
  - Go to RD if `req_we`=0, otherwise WR.
- RD: `mem_rd`=1 for exactly one cycle, then RCAP.
- RCAP:
  - `mem_rd`=0.
  - `mem_rdata` is valid in this cycle; at the edge closing RCAP, load it into `rsp_rdata` and set `rsp_valid`=1, `rsp_err`=0.
  - Then IDLE.
- WR: `mem_wr`=1 for exactly one cycle.
  - Without verify: set `rsp_valid`=1 at the edge closing WR, then IDLE.
  - With verify: go to VRD.
- VRD: `mem_rd`=1 for one cycle at the same address, then VCAP.
- VCAP:
  - Compare `mem_rdata` with the latched `mem_wdata`.
  - At the closing edge, set `rsp_valid`=1, `rsp_err`=(mismatch), `rsp_rdata`=`mem_rdata`.
  - Then IDLE.
- `mem_rd` and `mem_wr` are mutually exclusive in every cycle; this is a verified invariant.
- `mem_addr` and `mem_wdata` stay stable from the strobe cycle until the next accept.
- Inputs `req_*` are ignored outside IDLE.
- No address arithmetic. The AW-bit address is passed through unchanged, so all 32 locations (0..31) are reachable and there is no wrap logic.
- Reset values: state IDLE, `req_ready`=1 (it is decoded from state), `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `mem_rd`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0.

## Timing
Accept edge = E0. Cycle k is the cycle after edge Ek-1.

- Read:
  - `mem_rd` high in cycle 1.
  - Data sampled in cycle 2.
  - `rsp_valid` high in cycle 3, which is also IDLE (`req_ready`=1).
  - A back-to-back accept can happen at E3, so reads run at 1 per 3 cycles.
- Write, no verify:
  - `mem_wr` high in cycle 1.
  - `rsp_valid` and IDLE in cycle 2.
  - Writes run at 1 per 2 cycles.
- Write, with verify:
  - `mem_wr` in cycle 1, `mem_rd` in cycle 2, compare in cycle 3.
  - `rsp_valid` and IDLE in cycle 4.
- `rsp_valid` is high for exactly one cycle per accepted request and never without a prior accept.
- Reset mid-operation:
  - The state and all outputs clear at the reset edge. No response is issued for the aborted request.
  - A strobe already high in the cycle where `rst` is asserted is still sampled by the memory at that same edge. This is defined, allowed behaviour.
- `req_valid` asserted during reset is not accepted. The first accept is possible at the first edge with `rst`=0.

## Configuration
- Macro `MEM_MASTER_WRITE_VERIFY_EN`.
- Defined: WR→VRD→VCAP path, compare logic and `rsp_err` are compiled in. Write latency is 4 cycles to response.
- Undefined:
  - VRD and VCAP are removed and WR goes straight to IDLE.
  - `rsp_err` is tied to 0.
  - Write latency is 2 cycles to response.
  - The `rsp_rdata` value is unaffected by writes.

## Structure
- Package `mem_master_pkg` holds:
  - the state enum type `mm_state_t` (IDLE, RD, RCAP, WR, VRD, VCAP);
  - constants `MEM_AW`=5 and `MEM_DW`=8, shared with the memory and CPU top.
- No sub-module: a single flat FSM plus output registers. The top level instantiates `mem_master` next to the memory.

## Test plan
1. Write 0xA5 to addr 3, then read addr 3 → `mem_wr` one cycle with `mem_addr`=3 and `mem_wdata`=0xA5; `rsp_rdata`=0xA5 with `rsp_valid` 3 cycles after the read accept.
2. Write `addr`=`data` for all 0..31, then read all 31..0 → every response matches, including addr 0 and addr 31; `mem_rd` and `mem_wr` are never high together.
3. Hold `req_valid` high with alternating read/write → `req_ready` high only in IDLE; exactly one `rsp_valid` pulse per accept; read and write spacing match the Timing section.
4. With verify: the memory model corrupts addr 7 to return 0x00 after writing 0x3C → `rsp_err`=1 with `rsp_valid` in cycle 4; a clean write to addr 8 gives `rsp_err`=0.
5. Assert `rst` in cycle 2 of a read → next cycle IDLE, `mem_rd`=0, `rsp_valid`=0, `rsp_rdata`=0, and no response pulse follows.
6. Hold `req_valid`=1 during reset → no accept until the first edge with `rst`=0; all outputs are at their reset values throughout reset.
